// File: rtl/gost_key_expand.sv
// Kuznechik key-schedule engine: expands a 256-bit master key into round keys K1..K10,
// sharing one iterative R-transform between constant generation and the Feistel LSX steps.
module gost_key_expand (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] master_key,
  output logic         busy,
  output logic         done,
  output logic         key_we,
  output logic [3:0]   key_idx,
  output logic [127:0] key_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WR_A  = 3'd1;
  localparam logic [2:0] S_WR_B  = 3'd2;
  localparam logic [2:0] S_CONST = 3'd3;
  localparam logic [2:0] S_MIX   = 3'd4;
  localparam logic [2:0] S_LIN   = 3'd5;
  localparam logic [2:0] S_UPD   = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  // l() coefficients, byte i of this vector multiplies input byte a_i (a15 = MSB).
  localparam logic [127:0] LCOEF = 128'h94208510c2c001fb01c0c21085209401;

  // pi substitution table, entry 0 in the most-significant byte.
  localparam logic [2047:0] PI_TBL = {
    128'hfceedd11cf6e3116fbc4fada23c5044d,
    128'he977f0db932e99ba1736f1bb14cd5fc1,
    128'hf918655ae25cef21811c3c428b018e4f,
    128'h058402aee36a8fa0060bed987fd4d31f,
    128'heb342c51eac848abf22a68a2fd3acecc,
    128'hb5700e56080c7612bf7213479cb75d87,
    128'h15a19629107b9ac7f391786f9d9eb2b1,
    128'h3275193dff358a7e6d54c680c3bd0d57,
    128'hdff524a93ea843c9d779d6f67c22b903,
    128'he00fecde7a94b0bcdce828504e330a4a,
    128'ha79760731e0062441ab83882649f2641,
    128'had454692275e552f8ca3a57d69d5953b,
    128'h0758b34086ac1df730376be488d9e789,
    128'he11b83494c3ff8fe8d53aa90cad88561,
    128'h207167a42d2b095bcb9b25d0bee56c52,
    128'h59a674d2e6f4b4c0d166afc2394b63b6
  };

  logic [2:0]   state;
  logic [127:0] k1;
  logic [127:0] k2;
  logic [127:0] acc;
  logic [5:0]   j;
  logic [2:0]   pass;
  logic [3:0]   step;

  logic [127:0] r_in;
  logic [127:0] r_out;
  logic [127:0] s_out;

  // GF(2^8) multiply modulo x^8+x^7+x^6+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
    end
    return p;
  endfunction

  // One R step: the linear combination enters at the top, the lowest byte drops out.
  function automatic logic [127:0] r_step(input logic [127:0] a);
    logic [7:0] l;
    l = 8'h00;
    for (int i = 0; i < 16; i++)
      l = l ^ gf_mul(a[8*i +: 8], LCOEF[8*i +: 8]);
    return {l, a[127:8]};
  endfunction

  function automatic logic [7:0] pi_sub(input logic [7:0] b);
    return PI_TBL[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [127:0] s_layer(input logic [127:0] a);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[8*i +: 8] = pi_sub(a[8*i +: 8]);
    return r;
  endfunction

  // The first CONST cycle seeds the shared R unit with Vec128(j) instead of acc.
  always_comb begin
    r_in  = (state == S_CONST && step == 4'd0) ? {122'b0, j} : acc;
    r_out = r_step(r_in);
    s_out = s_layer(k1 ^ acc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      k1       <= '0;
      k2       <= '0;
      acc      <= '0;
      j        <= '0;
      pass     <= '0;
      step     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      key_we   <= 1'b0;
      key_idx  <= '0;
      key_data <= '0;
    end else begin
      key_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            k1    <= master_key[255:128];
            k2    <= master_key[127:0];
            j     <= 6'd1;
            pass  <= 3'd0;
            step  <= 4'd0;
            busy  <= 1'b1;
            state <= S_WR_A;
          end else begin
            busy <= 1'b0;
          end
        end
        S_WR_A: begin
          key_we   <= 1'b1;
          key_idx  <= {pass, 1'b0};
          key_data <= k1;
          state    <= S_WR_B;
        end
        S_WR_B: begin
          key_we   <= 1'b1;
          key_idx  <= {pass, 1'b1};
          key_data <= k2;
          step     <= 4'd0;
          state    <= (pass == 3'd4) ? S_DONE : S_CONST;
        end
        S_CONST: begin
          acc  <= r_out;
          step <= step + 4'd1;
          if (step == 4'd15) state <= S_MIX;
        end
        S_MIX: begin
          acc   <= s_out;
          state <= S_LIN;
        end
        S_LIN: begin
          acc  <= r_out;
          step <= step + 4'd1;
          if (step == 4'd15) state <= S_UPD;
        end
        S_UPD: begin
          k1 <= acc ^ k2;
          k2 <= k1;
          if (j != 6'd32) j <= j + 6'd1;
          // Every eighth iteration completes a pair of round keys.
          if (j[2:0] == 3'd0) begin
            pass  <= pass + 3'd1;
            state <= S_WR_A;
          end else begin
            state <= S_CONST;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gost_key_expand.sv
// Randomised and known-answer bench for gost_key_expand against a byte-queue
// reference of the Kuznechik key schedule and cipher.
module tb_gost_key_expand;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [255:0] master_key = '0;
  logic         busy;
  logic         done;
  logic         key_we;
  logic [3:0]   key_idx;
  logic [127:0] key_data;

  always #5 clk = ~clk;

  gost_key_expand dut (
    .clk(clk), .rst_n(rst_n), .start(start), .master_key(master_key),
    .busy(busy), .done(done), .key_we(key_we), .key_idx(key_idx), .key_data(key_data)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [127:0] exp_k [10];
  logic [127:0] store [10];

  localparam logic [255:0] RFC_KEY =
    256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
  localparam logic [127:0] RFC_C1 = 128'h6ea276726c487ab85d27bd10dd849401;
  localparam logic [127:0] RFC_PT = 128'h1122334455667700ffeeddccbbaa9988;
  localparam logic [127:0] RFC_CT = 128'h7f679d90bebc24305a468d42b9d4edcd;

  localparam int PI_T [256] = '{
    252,238,221,17,207,110,49,22,251,196,250,218,35,197,4,77,
    233,119,240,219,147,46,153,186,23,54,241,187,20,205,95,193,
    249,24,101,90,226,92,239,33,129,28,60,66,139,1,142,79,
    5,132,2,174,227,106,143,160,6,11,237,152,127,212,211,31,
    235,52,44,81,234,200,72,171,242,42,104,162,253,58,206,204,
    181,112,14,86,8,12,118,18,191,114,19,71,156,183,93,135,
    21,161,150,41,16,123,154,199,243,145,120,111,157,158,178,177,
    50,117,25,61,255,53,138,126,109,84,198,128,195,189,13,87,
    223,245,36,169,62,168,67,201,215,121,214,246,124,34,185,3,
    224,15,236,222,122,148,176,188,220,232,40,80,78,51,10,74,
    167,151,96,115,30,0,98,68,26,184,56,130,100,159,38,65,
    173,69,70,146,39,94,85,47,140,163,165,125,105,213,149,59,
    7,88,179,64,134,172,29,247,48,55,107,228,136,217,231,137,
    225,27,131,73,76,63,248,254,141,83,170,144,202,216,133,97,
    32,113,103,164,45,43,9,91,203,155,37,208,190,229,108,82,
    89,166,116,210,230,244,180,192,209,102,175,194,57,75,99,182
  };

  // Coefficients in a15..a0 order.
  localparam int LC [16] = '{148,32,133,16,194,192,1,251,1,192,194,16,133,32,148,1};

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Carry-less product followed by polynomial reduction by 0x1C3.
  function automatic int gm(input int a, input int b);
    int prod;
    prod = 0;
    for (int i = 0; i < 8; i++)
      if ((b >> i) & 1) prod = prod ^ (a << i);
    for (int k = 14; k >= 8; k--)
      if ((prod >> k) & 1) prod = prod ^ (32'h1C3 << (k - 8));
    return prod & 255;
  endfunction

  function automatic logic [127:0] m_l(input logic [127:0] v);
    int q[$];
    int l;
    logic [127:0] r;
    for (int i = 15; i >= 0; i--) q.push_back(int'(v[8*i +: 8]));
    repeat (16) begin
      l = 0;
      for (int k = 0; k < 16; k++) l = l ^ gm(q[k], LC[k]);
      q.push_front(l);
      void'(q.pop_back());
    end
    r = '0;
    for (int k = 0; k < 16; k++) r[8*(15-k) +: 8] = 8'(q[k]);
    return r;
  endfunction

  function automatic logic [127:0] m_s(input logic [127:0] v);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'(PI_T[int'(v[8*i +: 8])]);
    return r;
  endfunction

  task automatic model_keys(input logic [255:0] key);
    logic [127:0] a, b, c, t;
    a = key[255:128];
    b = key[127:0];
    exp_k[0] = a;
    exp_k[1] = b;
    for (int i = 1; i <= 32; i++) begin
      c = m_l(128'(i));
      t = m_l(m_s(a ^ c));
      {a, b} = {t ^ b, a};
      if (i % 8 == 0) begin
        exp_k[i/4]     = a;
        exp_k[i/4 + 1] = b;
      end
    end
  endtask

  function automatic logic [127:0] m_enc(input logic [127:0] pt);
    logic [127:0] x;
    x = pt;
    for (int r = 0; r < 9; r++) x = m_l(m_s(x ^ store[r]));
    return x ^ store[9];
  endfunction

  function automatic int wr_cycle(input int n);
    if (n < 2) return n + 1;
    return 275 + 274 * ((n - 2) / 2) + (n % 2);
  endfunction

  task automatic set_rfc();
    exp_k[0] = 128'h8899aabbccddeeff0011223344556677;
    exp_k[1] = 128'hfedcba98765432100123456789abcdef;
    exp_k[2] = 128'hdb31485315694343228d6aef8cc78c44;
    exp_k[3] = 128'h3d4553d8e9cfec6815ebadc40a9ffd04;
    exp_k[4] = 128'h57646468c44a5e28d3e59246f429f1ac;
    exp_k[5] = 128'hbd079435165c6432b532e82834da581b;
    exp_k[6] = 128'h51e640757e8745de705727265a0098b1;
    exp_k[7] = 128'h5a7925017b9fdd3ed72a91a22286f984;
    exp_k[8] = 128'hbb44e25378c73123a5f32f73cdb6e517;
    exp_k[9] = 128'h72e9dd7416bcf45b755dbaa88e4a4043;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"},  256'(busy),     256'(0));
    chk({tag, "_done"},  256'(done),     256'(0));
    chk({tag, "_we"},    256'(key_we),   256'(0));
    chk({tag, "_idx"},   256'(key_idx),  256'(0));
    chk({tag, "_data"},  256'(key_data), 256'(0));
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Full run from acceptance edge T through T+1100 against exp_k.
  task automatic run_check(input logic [255:0] key, input bit hold, input bit probe);
    int nw, done_cnt, done_cyc;
    bit xseen;
    nw = 0; done_cnt = 0; done_cyc = -1; xseen = 1'b0;
    @(negedge clk);
    master_key = key;
    start = 1'b1;
    @(posedge clk); #1;
    chk("busy_accept", 256'(busy), 256'(1));
    if (!hold) start = 1'b0;
    for (int cyc = 1; cyc <= 1100; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 10) master_key = hold ? '1 : {8{$urandom()}};
      if ($isunknown({busy, done, key_we, key_idx, key_data})) xseen = 1'b1;
      if (probe && cyc == 18) chk("c1_probe", 256'(dut.acc), 256'(RFC_C1));
      if (key_we) begin
        if (nw < 10) begin
          chk($sformatf("idx_w%0d", nw),  256'(key_idx),  256'(nw));
          chk($sformatf("data_k%0d", nw + 1), 256'(key_data), 256'(exp_k[nw]));
          chk($sformatf("cyc_k%0d", nw + 1),  256'(cyc),      256'(wr_cycle(nw)));
          store[key_idx] = key_data;
        end
        nw++;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (cyc == 1099) chk("busy_at_done", 256'(busy), 256'(1));
      if (cyc == 1100) chk("busy_after", 256'(busy), 256'(hold));
    end
    chk("write_count", 256'(nw), 256'(10));
    chk("done_count", 256'(done_cnt), 256'(1));
    chk("done_cycle", 256'(done_cyc), 256'(1099));
    chk("no_x", 256'(xseen), 256'(0));
  endtask

  initial begin
    logic [255:0] rk;
    int nw;

    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Known-answer run, constant probe and integration encryption.
    set_rfc();
    run_check(RFC_KEY, 1'b0, 1'b1);
    chk("encrypt", 256'(m_enc(RFC_PT)), 256'(RFC_CT));

    // start held high, key changed at T+10: reaccepted at T+1100.
    run_check(RFC_KEY, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("reaccept_we", 256'(key_we), 256'(1));
    chk("reaccept_idx", 256'(key_idx), 256'(0));
    chk("reaccept_data", 256'(key_data), 256'({128{1'b1}}));
    start = 1'b0;
    reset_pulse();

    // Asynchronous reset mid-run.
    @(negedge clk);
    master_key = RFC_KEY;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nw = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (key_we) nw++;
    end
    chk("no_wr_after_rst", 256'(nw), 256'(0));
    chk("idle_after_rst", 256'(busy), 256'(0));
    set_rfc();
    run_check(RFC_KEY, 1'b0, 1'b1);

    // All-zero key.
    model_keys('0);
    chk("zero_k1", 256'(exp_k[0]), 256'(0));
    run_check('0, 1'b0, 1'b0);

    // Random keys.
    for (int r = 0; r < 2; r++) begin
      rk = {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
      model_keys(rk);
      run_check(rk, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
